// File: rtl/time_cnt_chain.sv
// Four-stage cascaded modulo time counter with up/down direction, run-control FSM,
// load/clear and countdown completion. Optional alarm compare: TIME_CNT_CHAIN_ALARM_EN.
module time_cnt_chain #(
    parameter int MOD0 = 100,
    parameter int MOD1 = 60,
    parameter int MOD2 = 60,
    parameter int MOD3 = 24,
    parameter int W0   = 7,
    parameter int W1   = 6,
    parameter int W2   = 6,
    parameter int W3   = 5,
    localparam int TW  = W0 + W1 + W2 + W3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_tick,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_clear,
    input  logic          i_dir,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    output logic [TW-1:0] o_time,
    output logic [3:0]    o_carry,
    output logic          o_wrap,
    output logic          o_done,
    output logic          o_running
`ifdef TIME_CNT_CHAIN_ALARM_EN
   ,input  logic [TW-1:0] i_alarm_val,
    input  logic          i_alarm_arm,
    output logic          o_alarm
`endif
);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DONE} state_t;

    localparam logic [W0-1:0] MAX0 = W0'(MOD0 - 1);
    localparam logic [W1-1:0] MAX1 = W1'(MOD1 - 1);
    localparam logic [W2-1:0] MAX2 = W2'(MOD2 - 1);
    localparam logic [W3-1:0] MAX3 = W3'(MOD3 - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] time_q, time_d;
    logic [3:0]    carry_d;
    logic          wrap_d;
    logic          step;
    logic          tick_en;
    logic          zero_now;
    logic          dn_zero;

    logic [W0-1:0] f0, u0, d0, l0, c0;
    logic [W1-1:0] f1, u1, d1, l1, c1;
    logic [W2-1:0] f2, u2, d2, l2, c2;
    logic [W3-1:0] f3, u3, d3, l3, c3;
    logic [3:0]    up_c, dn_b;

    assign {f3, f2, f1, f0} = time_q;
    assign {l3, l2, l1, l0} = i_load_val;

    // Out-of-range load fields saturate to the stage maximum, independently.
    assign c0 = (l0 > MAX0) ? MAX0 : l0;
    assign c1 = (l1 > MAX1) ? MAX1 : l1;
    assign c2 = (l2 > MAX2) ? MAX2 : l2;
    assign c3 = (l3 > MAX3) ? MAX3 : l3;

    // Whole chain resolves in one edge: stage k moves only when all lower stages wrap/borrow.
    assign up_c[0] = (f0 == MAX0);
    assign up_c[1] = up_c[0] && (f1 == MAX1);
    assign up_c[2] = up_c[1] && (f2 == MAX2);
    assign up_c[3] = up_c[2] && (f3 == MAX3);

    assign dn_b[0] = (f0 == '0);
    assign dn_b[1] = dn_b[0] && (f1 == '0);
    assign dn_b[2] = dn_b[1] && (f2 == '0);
    assign dn_b[3] = dn_b[2] && (f3 == '0);

    assign u0 = up_c[0] ? '0 : f0 + 1'b1;
    assign u1 = up_c[0] ? (up_c[1] ? '0 : f1 + 1'b1) : f1;
    assign u2 = up_c[1] ? (up_c[2] ? '0 : f2 + 1'b1) : f2;
    assign u3 = up_c[2] ? (up_c[3] ? '0 : f3 + 1'b1) : f3;

    assign d0 = dn_b[0] ? MAX0 : f0 - 1'b1;
    assign d1 = dn_b[0] ? (dn_b[1] ? MAX1 : f1 - 1'b1) : f1;
    assign d2 = dn_b[1] ? (dn_b[2] ? MAX2 : f2 - 1'b1) : f2;
    assign d3 = dn_b[2] ? (dn_b[3] ? MAX3 : f3 - 1'b1) : f3;

    assign zero_now = (time_q == '0);
    assign dn_zero  = ({d3, d2, d1, d0} == '0);
    assign tick_en  = i_tick && (state_q == ST_RUN) && !i_clear && !i_load;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        time_d  = time_q;
        carry_d = '0;
        wrap_d  = 1'b0;
        step    = 1'b0;

        if (i_clear) begin
            time_d = '0;
        end else if (i_load) begin
            time_d = {c3, c2, c1, c0};
        end else if (tick_en) begin
            if (!i_dir) begin
                time_d  = {u3, u2, u1, u0};
                carry_d = up_c;
                wrap_d  = up_c[3];
                step    = 1'b1;
            end else if (!zero_now) begin
                time_d  = {d3, d2, d1, d0};
                carry_d = dn_zero ? 4'b0000 : dn_b;
                step    = 1'b1;
            end
        end

        unique case (state_q)
            ST_STOP: if (i_start && !i_stop) state_d = ST_RUN;
            ST_RUN: begin
                if (i_stop)
                    state_d = ST_STOP;
                else if (tick_en && i_dir && (zero_now || dn_zero))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_stop || i_clear || i_load)
                    state_d = ST_STOP;
                else if (i_start && !zero_now)
                    state_d = ST_RUN;
            end
            default: state_d = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STOP;
            time_q    <= '0;
            o_carry   <= '0;
            o_wrap    <= 1'b0;
            o_done    <= 1'b0;
            o_running <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            time_q    <= time_d;
            o_carry   <= carry_d;
            o_wrap    <= wrap_d;
            o_done    <= (state_d == ST_DONE);
            o_running <= (state_d == ST_RUN);
        end
    end

    assign o_time = time_q;

`ifdef TIME_CNT_CHAIN_ALARM_EN
    // Fires only on a counted step that lands on the alarm value; clear/load never fire it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_alarm <= 1'b0;
        else
            o_alarm <= i_alarm_arm && step && (time_d == i_alarm_val);
    end
`else
    logic unused_step;
    assign unused_step = step;
`endif

endmodule

// File: tb/tb_time_cnt_chain.sv
// Directed self-checking bench for time_cnt_chain (default build, 100/60/60/24 moduli).
module tb_time_cnt_chain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_tick, i_start, i_stop, i_clear, i_dir, i_load;
    logic [23:0] i_load_val;
    logic [23:0] o_time;
    logic [3:0]  o_carry;
    logic        o_wrap, o_done, o_running;

    int n_checks = 0;
    int n_fail   = 0;

    time_cnt_chain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tick     (i_tick),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_clear    (i_clear),
        .i_dir      (i_dir),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .o_time     (o_time),
        .o_carry    (o_carry),
        .o_wrap     (o_wrap),
        .o_done     (o_done),
        .o_running  (o_running)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] tv(input int h, input int m, input int s, input int c);
        return {h[4:0], m[5:0], s[5:0], c[6:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1; cyc(); i_start = 1'b0;
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1; cyc(); i_stop = 1'b0;
    endtask

    task automatic load(input logic [23:0] v);
        i_load_val = v; i_load = 1'b1; cyc(); i_load = 1'b0;
    endtask

    task automatic tick();
        i_tick = 1'b1; cyc(); i_tick = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {i_tick, i_start, i_stop, i_clear, i_dir, i_load} = '0;
        i_load_val = '0;
        #7;
        check("rst_time",    32'(o_time), 32'(0));
        check("rst_carry",   32'(o_carry), 32'(0));
        check("rst_wrap",    32'(o_wrap), 32'(0));
        check("rst_done",    32'(o_done), 32'(0));
        check("rst_running", 32'(o_running), 32'(0));
        cyc();
        rst_n = 1'b1;

        // Up count through one full stage-0 cycle.
        pulse_start();
        check("start_running", 32'(o_running), 32'(1));
        for (int i = 1; i <= 100; i++) begin
            tick();
            check("up_time",   32'(o_time), 32'(tv(0, 0, i / 100, i % 100)));
            check("up_carry0", 32'(o_carry), (i == 100) ? 32'(1) : 32'(0));
        end
        cyc();
        check("up_carry_clr", 32'(o_carry), 32'(0));
        check("up_hold",      32'(o_time), 32'(tv(0, 0, 1, 0)));

        // Full-chain wrap.
        load(tv(23, 59, 59, 99));
        pulse_start();
        check("wrap_load", 32'(o_time), 32'(tv(23, 59, 59, 99)));
        tick();
        check("wrap_time",  32'(o_time), 32'(0));
        check("wrap_carry", 32'(o_carry), 32'(4'b1111));
        check("wrap_pulse", 32'(o_wrap), 32'(1));
        cyc();
        check("wrap_carry_clr", 32'(o_carry), 32'(0));
        check("wrap_pulse_clr", 32'(o_wrap), 32'(0));
        check("wrap_running",   32'(o_running), 32'(1));

        // Countdown to completion.
        i_dir = 1'b1;
        load(tv(0, 0, 1, 0));
        tick();
        check("dn_time",  32'(o_time), 32'(tv(0, 0, 0, 99)));
        check("dn_carry", 32'(o_carry), 32'(4'b0001));
        for (int j = 1; j <= 98; j++) begin
            tick();
            check("dn_step", 32'(o_time), 32'(99 - j));
        end
        tick();
        check("dn_zero_time",  32'(o_time), 32'(0));
        check("dn_zero_carry", 32'(o_carry), 32'(0));
        check("dn_done",       32'(o_done), 32'(1));
        check("dn_not_run",    32'(o_running), 32'(0));
        tick(); tick();
        check("done_ignore_tick", 32'(o_time), 32'(0));
        pulse_start();
        check("done_start_done", 32'(o_done), 32'(1));
        check("done_start_run",  32'(o_running), 32'(0));
        pulse_stop();
        check("done_stop_done", 32'(o_done), 32'(0));
        check("done_stop_run",  32'(o_running), 32'(0));

        // Clear coincident with tick in RUN.
        i_dir = 1'b0;
        load(tv(0, 0, 5, 99));
        pulse_start();
        i_clear = 1'b1; i_tick = 1'b1; cyc(); i_clear = 1'b0; i_tick = 1'b0;
        check("clr_time",    32'(o_time), 32'(0));
        check("clr_carry",   32'(o_carry), 32'(0));
        check("clr_running", 32'(o_running), 32'(1));

        // Load coincident with tick suppresses the tick.
        i_tick = 1'b1; load(tv(0, 0, 0, 5)); i_tick = 1'b0;
        check("ld_tick_time", 32'(o_time), 32'(tv(0, 0, 0, 5)));

        // Start and stop together: stop wins.
        i_start = 1'b1; i_stop = 1'b1; cyc(); i_start = 1'b0; i_stop = 1'b0;
        check("start_stop", 32'(o_running), 32'(0));

        // Clamped load in STOP; ticks ignored. 63 is the largest value a 6-bit field can carry.
        load(tv(30, 63, 60, 120));
        check("clamp_time", 32'(o_time), 32'(tv(23, 59, 59, 99)));
        tick(); tick(); tick();
        check("stop_ignore",  32'(o_time), 32'(tv(23, 59, 59, 99)));
        check("stop_running", 32'(o_running), 32'(0));

        // Multi-stage borrow.
        i_dir = 1'b1;
        load(tv(1, 0, 0, 0));
        pulse_start();
        tick();
        check("borrow_time",  32'(o_time), 32'(tv(0, 59, 59, 99)));
        check("borrow_carry", 32'(o_carry), 32'(4'b0111));

        // Down tick at all-zero in RUN goes straight to DONE.
        i_clear = 1'b1; cyc(); i_clear = 1'b0;
        check("zero_clear_run", 32'(o_running), 32'(1));
        tick();
        check("zero_tick_time", 32'(o_time), 32'(0));
        check("zero_tick_done", 32'(o_done), 32'(1));
        pulse_stop();

        // Asynchronous reset mid-count.
        i_dir = 1'b0;
        load(tv(0, 1, 2, 3));
        pulse_start();
        i_tick = 1'b1; cyc();
        check("pre_rst_time", 32'(o_time), 32'(tv(0, 1, 2, 4)));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_time",    32'(o_time), 32'(0));
        check("async_rst_running", 32'(o_running), 32'(0));
        check("async_rst_carry",   32'(o_carry), 32'(0));
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_rst_tick_time", 32'(o_time), 32'(0));
        check("post_rst_tick_run",  32'(o_running), 32'(0));
        i_tick = 1'b0;
        pulse_start();
        tick();
        check("post_rst_run_time", 32'(o_time), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
